// File: rtl/z80_bridge_pkg.sv
// Shared types and constants for the Z80 to GPU RAM bus bridge.
package z80_bridge_pkg;
  typedef enum logic [2:0] {IDLE, MEM_WR, MEM_RD, RD_WAIT, BUS_HOLD} state_e;

  localparam logic [1:0] DEF_WIN_SEL     = 2'b11;
  localparam logic [7:0] DEF_PAGE_PORT   = 8'hF0;
  localparam logic [7:0] DEF_STAT_PORT   = 8'hF1;
  localparam int         DEF_TIMEOUT     = 15;
  localparam int         DEF_SYNC_STAGES = 2;
  localparam int         TMO_W           = 4;

  localparam int STAT_ERR_BIT  = 0;
  localparam int STAT_BUSY_BIT = 1;

  function automatic logic [7:0] status_byte(input logic busy, input logic err);
    logic [7:0] s;
    s                = '0;
    s[STAT_BUSY_BIT] = busy;
    s[STAT_ERR_BIT]  = err;
    return s;
  endfunction
endpackage

// File: rtl/sync_fall_det.sv
// Multi-flop synchroniser for an active-low async strobe plus a one-clock
// falling-edge pulse on the synchronised value.
module sync_fall_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic sync,
  output logic fall
);
  logic [STAGES-1:0] sh_q, sh_d;
  logic              prev_q, prev_d;

  always_comb begin
    sh_d   = {sh_q[STAGES-2:0], d};
    prev_d = sh_q[STAGES-1];
  end

  // Strobes are active-low, so the idle (reset) level is 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '1;
      prev_q <= 1'b1;
    end else begin
      sh_q   <= sh_d;
      prev_q <= prev_d;
    end
  end

  assign sync = sh_q[STAGES-1];
  assign fall = prev_q & ~sh_q[STAGES-1];
endmodule

// File: rtl/z80_bus_bridge.sv
// Z80 bus to GPU RAM mux Port A bridge: strobe sync, window/IO decode, read wait.
// Define Z80_WAIT_EN to drive the Z80 WAIT line during GPU reads.
module z80_bus_bridge
  import z80_bridge_pkg::*;
#(
  parameter logic [1:0] WIN_SEL     = DEF_WIN_SEL,
  parameter logic [7:0] PAGE_PORT   = DEF_PAGE_PORT,
  parameter logic [7:0] STAT_PORT   = DEF_STAT_PORT,
  parameter int         TIMEOUT     = DEF_TIMEOUT,
  parameter int         SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] z80_addr,
  input  logic [7:0]  z80_data_in,
  input  logic        z80_mreq_n,
  input  logic        z80_iorq_n,
  input  logic        z80_rd_n,
  input  logic        z80_wr_n,
  input  logic        z80_m1_n,
  output logic [7:0]  z80_data_out,
  output logic        z80_data_oe,
  output logic        z80_wait_n,
  output logic        wr_ena,
  output logic        rd_req,
  output logic [19:0] gpu_address,
  output logic [7:0]  gpu_wdata,
  input  logic [7:0]  gpu_rdata,
  input  logic        gpu_rd_rdy,
  output logic [5:0]  page,
  output logic        timeout_err
);
`ifdef Z80_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic rd_s, rd_fall, wr_s, wr_fall;

  sync_fall_det #(.STAGES(SYNC_STAGES)) u_rd_sync (
    .clk(clk), .rst_n(reset), .d(z80_rd_n), .sync(rd_s), .fall(rd_fall));
  sync_fall_det #(.STAGES(SYNC_STAGES)) u_wr_sync (
    .clk(clk), .rst_n(reset), .d(z80_wr_n), .sync(wr_s), .fall(wr_fall));

  // Qualifiers only need a level, no edge detect.
  logic [SYNC_STAGES-1:0] mreq_sh_q, mreq_sh_d, iorq_sh_q, iorq_sh_d, m1_sh_q, m1_sh_d;
  logic mreq_s, iorq_s, m1_s;

  always_comb begin
    mreq_sh_d = {mreq_sh_q[SYNC_STAGES-2:0], z80_mreq_n};
    iorq_sh_d = {iorq_sh_q[SYNC_STAGES-2:0], z80_iorq_n};
    m1_sh_d   = {m1_sh_q[SYNC_STAGES-2:0], z80_m1_n};
  end

  assign mreq_s = mreq_sh_q[SYNC_STAGES-1];
  assign iorq_s = iorq_sh_q[SYNC_STAGES-1];
  assign m1_s   = m1_sh_q[SYNC_STAGES-1];

  logic io_sel, mem_sel, start;
  assign io_sel  = ~iorq_s & m1_s;
  assign mem_sel = ~mreq_s;
  assign start   = (rd_fall | wr_fall) & (io_sel | mem_sel);

  state_e           state_q, state_d;
  logic [5:0]       page_q, page_d;
  logic             terr_q, terr_d;
  logic [19:0]      addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d, dout_q, dout_d;
  logic             oe_q, oe_d, wait_q, wait_d, wr_q, wr_d, rd_q, rd_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    terr_d  = terr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    oe_d    = oe_q;
    wait_d  = 1'b1;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (start) begin
        if (io_sel) begin
          if (wr_fall && z80_addr[7:0] == PAGE_PORT) begin
            page_d  = z80_data_in[5:0];
            state_d = BUS_HOLD;
          end else if (rd_fall && z80_addr[7:0] == PAGE_PORT) begin
            dout_d  = {2'b00, page_q};
            oe_d    = 1'b1;
            state_d = BUS_HOLD;
          end else if (rd_fall && z80_addr[7:0] == STAT_PORT) begin
            dout_d  = status_byte(state_q != IDLE, terr_q);
            terr_d  = 1'b0;
            oe_d    = 1'b1;
            state_d = BUS_HOLD;
          end
        end else if (z80_addr[15:14] == WIN_SEL) begin
          addr_d = {page_q, z80_addr[13:0]};
          if (wr_fall) begin
            wdata_d = z80_data_in;
            wr_d    = 1'b1;
            state_d = MEM_WR;
          end else begin
            rd_d    = 1'b1;
            state_d = MEM_RD;
          end
        end
      end
      MEM_WR: state_d = BUS_HOLD;
      MEM_RD: begin
        cnt_d   = '0;
        wait_d  = !WAIT_EN;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        // Ready on the final counted clock beats the timeout.
        if (gpu_rd_rdy) begin
          dout_d  = gpu_rdata;
          oe_d    = 1'b1;
          state_d = BUS_HOLD;
        end else if (cnt_q == TMO_W'(TIMEOUT - 1)) begin
          dout_d  = 8'hFF;
          terr_d  = 1'b1;
          oe_d    = 1'b1;
          state_d = BUS_HOLD;
        end else begin
          cnt_d  = cnt_q + TMO_W'(1);
          wait_d = !WAIT_EN;
        end
      end
      BUS_HOLD: if (rd_s && wr_s) begin
        oe_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mreq_sh_q <= '1;
      iorq_sh_q <= '1;
      m1_sh_q   <= '1;
      state_q   <= IDLE;
      page_q    <= '0;
      terr_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      dout_q    <= '0;
      oe_q      <= 1'b0;
      wait_q    <= 1'b1;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      cnt_q     <= '0;
    end else begin
      mreq_sh_q <= mreq_sh_d;
      iorq_sh_q <= iorq_sh_d;
      m1_sh_q   <= m1_sh_d;
      state_q   <= state_d;
      page_q    <= page_d;
      terr_q    <= terr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      dout_q    <= dout_d;
      oe_q      <= oe_d;
      wait_q    <= wait_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
    end
  end

  assign z80_data_out = dout_q;
  assign z80_data_oe  = oe_q;
  assign z80_wait_n   = wait_q;
  assign wr_ena       = wr_q;
  assign rd_req       = rd_q;
  assign gpu_address  = addr_q;
  assign gpu_wdata    = wdata_q;
  assign page         = page_q;
  assign timeout_err  = terr_q;
endmodule
